core_bus_bridge: RTL and testbench
==================================

Name: core_bus_bridge

Overview:
- Sits directly downstream of the core top. Merges the core's instruction-fetch port (inst_addr/inst_ena/inst_ready/inst/bui_inst_valid) and its data port (data_addr/wmask/data_o/data_i/we/re/mem_finish) onto one single-outstanding memory request/response bus.
- Arbitrates between the two ports, aligns addresses, and extracts 32-bit instructions from 64-bit beats.
- Returns one-cycle completion pulses to the core and flags bus timeouts.

Parameters:
- ADDR_W, 64, core address width (pc and data address)
- DATA_W, 64, memory beat width
- TIMEOUT, 255, cycles to wait for mem_resp_valid before a forced error completion (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_addr  in  64  fetch address from core
- inst_ena  in  1  fetch request
- inst_ready  in  1  core can accept an instruction
- inst  out  32  fetched instruction
- bui_inst_valid  out  1  one-cycle pulse: inst is valid
- data_addr  in  64  load/store address
- wmask  in  8  byte write mask
- data_o  in  64  store data from core
- data_i  out  64  load data to core, raw aligned 64-bit word
- we  in  1  store request
- re  in  1  load request
- mem_finish  out  1  one-cycle pulse: data access complete
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  64  bus address, bits [2:0] forced to 0
- mem_req_we  out  1  bus write
- mem_req_wmask  out  8  bus byte mask; 0x00 on reads
- mem_req_wdata  out  64  bus write data
- mem_resp_valid  in  1  bus response
- mem_resp_data  in  64  bus read data
- bus_err  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- The clock and reset are clk and rst. There is one clock, and reset is synchronous and active-high.
- Reset: state IDLE. All outputs 0: inst, bui_inst_valid, data_i, mem_finish, mem_req_*, bus_err. The timeout counter is 0. rst asserted mid-transaction aborts it immediately. Any later mem_resp_valid for the aborted transaction is ignored while in IDLE.
- States: IDLE, DREQ, DRESP, IREQ, IRESP, DONE.
- IDLE arbitration:
  - (re|we) has priority over inst_ena&inst_ready, because the mem stage is the older instruction.
  - A data request captures addr, wmask, wdata and we, then goes to DREQ.
  - A fetch request captures inst_addr, then goes to IREQ.
  - If we and re are both high, the access is treated as a write.
- DREQ/IREQ:
  - mem_req_valid=1 with the captured fields.
  - Fields stay stable until mem_req_ready.
  - On the valid&ready cycle, go to DRESP/IRESP; mem_req_valid drops the next cycle.
- DRESP: on mem_resp_valid, register data_i=mem_resp_data (write: data_i unchanged) and mem_finish=1 for exactly one cycle, then go to DONE.
- IRESP: on mem_resp_valid, select inst = captured_addr[2] ? data[63:32] : data[31:0].
  - Pulse bui_inst_valid for one cycle, only if inst_ena is still 1 and inst_addr equals the captured address.
  - Otherwise discard the result; this is a redirect or flush.
  - In both cases go to DONE.
- DONE: lasts one cycle, with no new request sampled. This prevents reissuing the stale request the core still presents during the completion cycle. Then return to IDLE.
- Latency: request to completion pulse = 1 (IDLE capture) + bus accept wait + bus response wait + 1 (registered pulse). With zero-wait ready and response on the cycle after accept, the pulse appears 3 cycles after the request is first seen.
- Timeout:
  - The counter increments each cycle in DREQ/DRESP/IREQ/IRESP and clears on entering IDLE.
  - When it reaches TIMEOUT: set bus_err and complete with zero data (mem_finish pulse, or an inst pulse with 0x00000013 NOP if still wanted). Then go to DONE.
  - Set mem_req_valid=0.
- Held request fields never change between capture and completion, even if core inputs change.
- No inst or data output changes except at completion; inst holds its last value.

Test Plan:
- Fetch with zero-wait bus: inst_addr=0x80000004, inst_ena=inst_ready=1, resp data 0x00100093_00000013 -> mem_req_addr=0x80000000, inst=0x00100093, bui_inst_valid pulses 1 cycle, 3 cycles after request.
- Simultaneous re and inst_ena in IDLE: data_addr=0x80001008 -> data request issued first; mem_finish with data_i=resp word; fetch issued only after DONE→IDLE.
- Store with mem_req_ready low 4 cycles: we=1, wmask=0x0F, data_o=0xDEADBEEF -> mem_req_valid and fields stable for 5 cycles; mem_req_we=1; single mem_finish pulse; data_i unchanged.
- Fetch flushed: inst_addr changes from 0x80000010 to 0x80000100 during IRESP -> no bui_inst_valid for 0x80000010; next fetch targets 0x80000100.
- Timeout: re=1, bus never responds -> after 255 cycles bus_err=1 (sticky), mem_finish pulses with data_i=0, and the next request proceeds normally.
- rst asserted in DRESP -> next cycle all outputs 0 and state IDLE; a late mem_resp_valid does not generate mem_finish.

Source files
------------

// File: rtl/core_bus_bridge.sv
// core_bus_bridge
//
// Merges the core's instruction-fetch port and data port onto a single
// memory bus that allows one outstanding request. Data accesses win
// arbitration over fetches because the mem stage holds the older instruction.
// Addresses are aligned to the 64-bit beat, 32-bit instructions are picked
// out of the returned beat, and completions are signalled with registered
// one-cycle pulses. A bus that never answers is cut off after TIMEOUT busy
// cycles. The transaction then completes with zero data, and a sticky
// bus_err is raised.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   inst_addr        fetch address from the core
//   inst_ena         fetch request
//   inst_ready       core can accept an instruction
//   inst             fetched instruction (holds its last value)
//   bui_inst_valid   one-cycle pulse: inst is valid
//   data_addr        load/store address
//   wmask            byte write mask
//   data_o           store data from the core
//   data_i           load data to the core (raw aligned beat)
//   we, re           store / load request (both high = store)
//   mem_finish       one-cycle pulse: data access complete
//   mem_req_*        bus request channel (valid/ready handshake)
//   mem_resp_*       bus response channel
//   bus_err          sticky timeout flag, cleared only by rst
//
// DATA_W must be 64: instructions are selected from the two 32-bit halves of
// a beat. TIMEOUT must be in the range 1..255, because the counter is 8 bits.

module core_bus_bridge #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_ena,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic                bui_inst_valid,

  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [DATA_W-1:0]   data_o,
  output logic [DATA_W-1:0]   data_i,
  input  logic                we,
  input  logic                re,
  output logic                mem_finish,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,

  output logic                bus_err
);

  localparam logic [31:0] InstNop = 32'h0000_0013;
  // The timeout fires on the busy cycle at which the counter is about to reach TIMEOUT.
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDreq,
    StDresp,
    StIreq,
    StIresp,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0]     data_i_q, data_i_d;
  logic                  finish_q, finish_d;
  logic                  bus_err_q, bus_err_d;

  logic                  busy;
  logic                  timeout_hit;
  logic                  inst_wanted;
  logic [31:0]           resp_inst;

  assign busy = (state_q == StDreq) || (state_q == StDresp) ||
                (state_q == StIreq) || (state_q == StIresp);
  assign timeout_hit = busy && (cnt_q >= TimeoutLast);

  // A fetch result is delivered only if the core still asks for the same pc.
  // Otherwise the core has redirected or flushed since the fetch was issued.
  assign inst_wanted = inst_ena && (inst_addr == addr_q);
  assign resp_inst   = addr_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    data_i_d     = data_i_q;
    finish_d     = 1'b0;
    bus_err_d    = bus_err_q;

    // Saturate rather than wrap, so a late accept cannot dodge the timeout.
    if (busy && (cnt_q != 8'hff)) begin
      cnt_d = cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (re || we) begin
          addr_d  = data_addr;
          we_d    = we;
          wmask_d = we ? wmask : '0;
          wdata_d = we ? data_o : '0;
          state_d = StDreq;
        end else if (inst_ena && inst_ready) begin
          addr_d  = inst_addr;
          we_d    = 1'b0;
          wmask_d = '0;
          wdata_d = '0;
          state_d = StIreq;
        end
      end

      StDreq: begin
        if (mem_req_ready) begin
          state_d = StDresp;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          finish_d  = 1'b1;
          if (!we_q) data_i_d = '0;
          state_d   = StDone;
        end
      end

      StDresp: begin
        if (mem_resp_valid) begin
          finish_d = 1'b1;
          if (!we_q) data_i_d = mem_resp_data;
          state_d  = StDone;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          finish_d  = 1'b1;
          if (!we_q) data_i_d = '0;
          state_d   = StDone;
        end
      end

      StIreq: begin
        if (mem_req_ready) begin
          state_d = StIresp;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          if (inst_wanted) begin
            inst_d       = InstNop;
            inst_valid_d = 1'b1;
          end
          state_d = StDone;
        end
      end

      StIresp: begin
        if (mem_resp_valid) begin
          if (inst_wanted) begin
            inst_d       = resp_inst;
            inst_valid_d = 1'b1;
          end
          state_d = StDone;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          if (inst_wanted) begin
            inst_d       = InstNop;
            inst_valid_d = 1'b1;
          end
          state_d = StDone;
        end
      end

      // The core still presents the request it just had completed. This
      // dead cycle keeps that stale request from being issued a second time.
      StDone: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= 8'd0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      data_i_q     <= '0;
      finish_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      data_i_q     <= data_i_d;
      finish_q     <= finish_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req_valid  = (state_q == StDreq) || (state_q == StIreq);
  assign mem_req_addr   = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_req_we     = we_q;
  assign mem_req_wmask  = wmask_q;
  assign mem_req_wdata  = wdata_q;

  assign inst           = inst_q;
  assign bui_inst_valid = inst_valid_q;
  assign data_i         = data_i_q;
  assign mem_finish     = finish_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_core_bus_bridge.sv
module tb_core_bus_bridge;

  logic        clk;
  logic        rst;
  logic [63:0] inst_addr;
  logic        inst_ena;
  logic        inst_ready;
  logic [31:0] inst;
  logic        bui_inst_valid;
  logic [63:0] data_addr;
  logic [7:0]  wmask;
  logic [63:0] data_o;
  logic [63:0] data_i;
  logic        we;
  logic        re;
  logic        mem_finish;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_we;
  logic [7:0]  mem_req_wmask;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        bus_err;

  int vectors;
  int miscompares;

  core_bus_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .inst_addr      (inst_addr),
    .inst_ena       (inst_ena),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .bui_inst_valid (bui_inst_valid),
    .data_addr      (data_addr),
    .wmask          (wmask),
    .data_o         (data_o),
    .data_i         (data_i),
    .we             (we),
    .re             (re),
    .mem_finish     (mem_finish),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  // Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (mem_req_addr !== 64'h0) begin miscompares++;
      $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); end
    vectors++; if (bui_inst_valid !== 1'b0 || mem_finish !== 1'b0) begin miscompares++;
      $display("FAIL reset_pulses: got %b%b want 00", bui_inst_valid, mem_finish); end
    vectors++; if (inst !== 32'h0 || data_i !== 64'h0) begin miscompares++;
      $display("FAIL reset_data: got %h %h want 0 0", inst, data_i); end
    vectors++; if (bus_err !== 1'b0) begin miscompares++;
      $display("FAIL reset_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_fetch_zero_wait();
    inst_addr = 64'h8000_0004; inst_ena = 1'b1; inst_ready = 1'b1; mem_req_ready = 1'b1;
    tick();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin miscompares++;
      $display("FAIL fetch_req: got v=%b a=%h want 1 80000000", mem_req_valid, mem_req_addr); end
    vectors++; if (mem_req_we !== 1'b0 || mem_req_wmask !== 8'h00) begin miscompares++;
      $display("FAIL fetch_req_rd: got we=%b m=%h want 0 00", mem_req_we, mem_req_wmask); end
    tick();
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++;
      $display("FAIL fetch_valid_drop: got %b want 0", mem_req_valid); end
    mem_resp_valid = 1'b1; mem_resp_data = 64'h0010_0093_0000_0013;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (bui_inst_valid !== 1'b1 || inst !== 32'h0010_0093) begin miscompares++;
      $display("FAIL fetch_inst: got v=%b i=%h want 1 00100093", bui_inst_valid, inst); end
    inst_ena = 1'b0;
    tick();
    vectors++; if (bui_inst_valid !== 1'b0) begin miscompares++;
      $display("FAIL fetch_pulse_len: got %b want 0", bui_inst_valid); end
  endtask

  task automatic test_priority();
    re = 1'b1; data_addr = 64'h8000_1008;
    inst_ena = 1'b1; inst_addr = 64'h8000_000C; inst_ready = 1'b1; mem_req_ready = 1'b1;
    tick();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1008) begin miscompares++;
      $display("FAIL prio_data_first: got v=%b a=%h want 1 80001008", mem_req_valid,
               mem_req_addr); end
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h1122_3344_5566_7788;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (mem_finish !== 1'b1 || data_i !== 64'h1122_3344_5566_7788) begin
      miscompares++;
      $display("FAIL prio_load: got f=%b d=%h want 1 1122334455667788", mem_finish, data_i); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++;
      $display("FAIL prio_done_no_req: got %b want 0", mem_req_valid); end
    re = 1'b0;
    tick();
    vectors++; if (mem_req_valid !== 1'b0 || mem_finish !== 1'b0) begin miscompares++;
      $display("FAIL prio_idle: got v=%b f=%b want 0 0", mem_req_valid, mem_finish); end
    tick();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0008) begin miscompares++;
      $display("FAIL prio_fetch_after: got v=%b a=%h want 1 80000008", mem_req_valid,
               mem_req_addr); end
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hAAAA_AAAA_BBBB_BBBB;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (bui_inst_valid !== 1'b1 || inst !== 32'hAAAA_AAAA) begin miscompares++;
      $display("FAIL prio_fetch_inst: got v=%b i=%h want 1 aaaaaaaa", bui_inst_valid, inst); end
    inst_ena = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    we = 1'b1; wmask = 8'h0F; data_o = 64'h0000_0000_DEAD_BEEF; data_addr = 64'h8000_2010;
    mem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_2010 ||
                     mem_req_we !== 1'b1) begin miscompares++;
        $display("FAIL store_hold_%0d: got v=%b a=%h we=%b want 1 80002010 1", i,
                 mem_req_valid, mem_req_addr, mem_req_we); end
      vectors++; if (mem_req_wmask !== 8'h0F || mem_req_wdata !== 64'hDEAD_BEEF) begin
        miscompares++;
        $display("FAIL store_fields_%0d: got m=%h d=%h want 0f deadbeef", i, mem_req_wmask,
                 mem_req_wdata); end
      if (i == 0) begin
        wmask = 8'hFF; data_o = 64'h0; data_addr = 64'h0;
      end
      if (i == 4) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++;
      $display("FAIL store_accepted: got %b want 0", mem_req_valid); end
    mem_resp_valid = 1'b1; mem_resp_data = 64'h5555_5555_5555_5555;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (mem_finish !== 1'b1 || data_i !== 64'h1122_3344_5566_7788) begin
      miscompares++;
      $display("FAIL store_finish: got f=%b d=%h want 1 1122334455667788", mem_finish,
               data_i); end
    we = 1'b0;
    tick();
    vectors++; if (mem_finish !== 1'b0) begin miscompares++;
      $display("FAIL store_pulse_len: got %b want 0", mem_finish); end
  endtask

  task automatic test_flush();
    mem_req_ready = 1'b1;
    inst_addr = 64'h8000_0010; inst_ena = 1'b1; inst_ready = 1'b1;
    tick();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0010) begin miscompares++;
      $display("FAIL flush_req: got v=%b a=%h want 1 80000010", mem_req_valid, mem_req_addr); end
    tick();
    inst_addr = 64'h8000_0100;
    mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFE_F00D_1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (bui_inst_valid !== 1'b0 || inst !== 32'hAAAA_AAAA) begin miscompares++;
      $display("FAIL flush_discard: got v=%b i=%h want 0 aaaaaaaa", bui_inst_valid, inst); end
    tick();
    tick();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100) begin miscompares++;
      $display("FAIL flush_refetch: got v=%b a=%h want 1 80000100", mem_req_valid,
               mem_req_addr); end
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h0000_006F_0000_0113;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (bui_inst_valid !== 1'b1 || inst !== 32'h0000_0113) begin miscompares++;
      $display("FAIL flush_new_inst: got v=%b i=%h want 1 00000113", bui_inst_valid, inst); end
    inst_ena = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    re = 1'b1; data_addr = 64'h8000_3000; mem_req_ready = 1'b1;
    tick();
    vectors++; if (bus_err !== 1'b0 || mem_req_valid !== 1'b1) begin miscompares++;
      $display("FAIL timeout_start: got e=%b v=%b want 0 1", bus_err, mem_req_valid); end
    n = 0;
    while (mem_finish !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    vectors++; if (n != 255) begin miscompares++;
      $display("FAIL timeout_cycles: got %0d want 255", n); end
    vectors++; if (bus_err !== 1'b1 || data_i !== 64'h0) begin miscompares++;
      $display("FAIL timeout_result: got e=%b d=%h want 1 0", bus_err, data_i); end
    re = 1'b0;
    tick();
    vectors++; if (mem_finish !== 1'b0 || bus_err !== 1'b1) begin miscompares++;
      $display("FAIL timeout_sticky: got f=%b e=%b want 0 1", mem_finish, bus_err); end
    tick();
    re = 1'b1; data_addr = 64'h8000_3008;
    tick();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_3008) begin miscompares++;
      $display("FAIL timeout_next_req: got v=%b a=%h want 1 80003008", mem_req_valid,
               mem_req_addr); end
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (mem_finish !== 1'b1 || data_i !== 64'h77 || bus_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_next_done: got f=%b d=%h e=%b want 1 77 1", mem_finish, data_i,
               bus_err); end
    re = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    re = 1'b1; data_addr = 64'h8000_4000; mem_req_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; re = 1'b0;
    vectors++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0 || bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_bus: got v=%b a=%h e=%b want 0 0 0", mem_req_valid, mem_req_addr,
               bus_err); end
    vectors++; if (inst !== 32'h0 || data_i !== 64'h0 || mem_finish !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: got i=%h d=%h f=%b want 0 0 0", inst, data_i, mem_finish); end
    mem_resp_valid = 1'b1; mem_resp_data = 64'h99;
    tick();
    mem_resp_valid = 1'b0;
    vectors++; if (mem_finish !== 1'b0 || data_i !== 64'h0) begin miscompares++;
      $display("FAIL abort_late_resp: got f=%b d=%h want 0 0", mem_finish, data_i); end
    tick();
    vectors++; if (mem_finish !== 1'b0 || mem_req_valid !== 1'b0) begin miscompares++;
      $display("FAIL abort_quiet: got f=%b v=%b want 0 0", mem_finish, mem_req_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    inst_addr = '0; inst_ena = 1'b0; inst_ready = 1'b0;
    data_addr = '0; wmask = '0; data_o = '0; we = 1'b0; re = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

    test_reset();
    test_fetch_zero_wait();
    test_priority();
    test_store_wait();
    test_flush();
    test_timeout();
    test_reset_abort();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
